display_timings_multi: RTL and testbench

//  Mode-selectable video timing generator. Produces the screen position, sync,

---
 rtl/display_timings_pkg.sv | 43 ++++
 rtl/dt_axis_ctr.sv | 33 +++
 rtl/display_timings_multi.sv | 126 ++++++++++++
 tb/tb_display_timings_multi.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_timings_pkg.sv
// Timing descriptions shared by the multi-mode display timing generator.
// Each mode is described by its active size, porches and sync widths.
package display_timings_pkg;

  typedef struct packed {
    logic [15:0] hres;
    logic [15:0] hfp;
    logic [15:0] hs;
    logic [15:0] hbp;
    logic [15:0] vres;
    logic [15:0] vfp;
    logic [15:0] vs;
    logic [15:0] vbp;
    logic        hpol;
    logic        vpol;
  } timing_t;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
  } totals_t;

  // 640x480@60, 800x600@60, 1280x720@60
  localparam timing_t TIMINGS [0:2] = '{
    '{hres: 16'd640,  hfp: 16'd16,  hs: 16'd96,  hbp: 16'd48,
      vres: 16'd480,  vfp: 16'd10,  vs: 16'd2,   vbp: 16'd33,
      hpol: 1'b0, vpol: 1'b0},
    '{hres: 16'd800,  hfp: 16'd40,  hs: 16'd128, hbp: 16'd88,
      vres: 16'd600,  vfp: 16'd1,   vs: 16'd4,   vbp: 16'd23,
      hpol: 1'b1, vpol: 1'b1},
    '{hres: 16'd1280, hfp: 16'd110, hs: 16'd40,  hbp: 16'd220,
      vres: 16'd720,  vfp: 16'd5,   vs: 16'd5,   vbp: 16'd20,
      hpol: 1'b1, vpol: 1'b1}
  };

  function automatic totals_t totals(input timing_t t);
    totals_t r;
    r.h = t.hres + t.hfp + t.hs + t.hbp;
    r.v = t.vres + t.vfp + t.vs + t.vbp;
    return r;
  endfunction

endpackage

// File: rtl/dt_axis_ctr.sv
// One axis of the raster scan: counts 0..total-1 while enabled and flags the wrap.
// The next-state value is exported so outputs can be decoded without added latency.
module dt_axis_ctr #(
  parameter int               CORDW   = 12,
  parameter logic [CORDW-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CORDW-1:0] total,
  output logic [CORDW-1:0] q,
  output logic [CORDW-1:0] q_next,
  output logic             wrap
);

  assign wrap = en && (q == total - CORDW'(1));

  always_comb begin
    q_next = q;
    if (wrap)
      q_next = '0;
    else if (en)
      q_next = q + CORDW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= RST_VAL;
    else
      q <= q_next;
  end

endmodule

// File: rtl/display_timings_multi.sv
// Mode-selectable video timing generator with registered, zero-latency outputs.
// The active mode only changes on the edge that starts a new frame.
module display_timings_multi
  import display_timings_pkg::*;
#(
  parameter int CORDW    = 12,
  parameter int MODE_RST = 0,
  parameter int C_HRES   = 640,
  parameter int C_HFP    = 16,
  parameter int C_HS     = 96,
  parameter int C_HBP    = 48,
  parameter int C_VRES   = 480,
  parameter int C_VFP    = 10,
  parameter int C_VS     = 2,
  parameter int C_VBP    = 33,
  parameter bit C_HPOL   = 1'b0,
  parameter bit C_VPOL   = 1'b0
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  input  logic [1:0]       mode_req,
  output logic [1:0]       mode_act,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame,
  output logic             line
);

  localparam timing_t CUSTOM = '{
    hres: 16'(C_HRES), hfp: 16'(C_HFP), hs: 16'(C_HS), hbp: 16'(C_HBP),
    vres: 16'(C_VRES), vfp: 16'(C_VFP), vs: 16'(C_VS), vbp: 16'(C_VBP),
    hpol: C_HPOL, vpol: C_VPOL};

  localparam timing_t MODES [4] = '{TIMINGS[0], TIMINGS[1], TIMINGS[2], CUSTOM};
  localparam timing_t RST_T     = MODES[MODE_RST];
  localparam totals_t RST_TOT   = totals(RST_T);

  if (MODE_RST < 0 || MODE_RST > 3) begin : g_bad_mode
    $error("display_timings_multi: MODE_RST out of range");
  end

  // Every mode's largest coordinate (TOTAL-1) must be representable in CORDW bits.
  for (genvar m = 0; m < 4; m++) begin : g_chk
    localparam totals_t TOT = totals(MODES[m]);
    if (int'(TOT.h) > (1 << CORDW) || int'(TOT.v) > (1 << CORDW)) begin : g_bad
      $error("display_timings_multi: mode %0d totals do not fit in CORDW", m);
    end
  end

  timing_t          t_cur;
  timing_t          t_nxt;
  totals_t          tot_cur;
  logic [CORDW-1:0] h_total;
  logic [CORDW-1:0] v_total;
  logic [CORDW-1:0] nx;
  logic [CORDW-1:0] ny;
  logic             h_wrap;
  logic             v_wrap;
  logic [CORDW-1:0] hs_lo;
  logic [CORDW-1:0] hs_hi;
  logic [CORDW-1:0] vs_lo;
  logic [CORDW-1:0] vs_hi;

  assign tot_cur = totals(t_cur);
  assign h_total = CORDW'(tot_cur.h);
  assign v_total = CORDW'(tot_cur.v);

  dt_axis_ctr #(
    .CORDW  (CORDW),
    .RST_VAL(CORDW'(RST_TOT.h - 16'd1))
  ) u_h (
    .clk   (clk_pix),
    .rst_n (rst_pix_n),
    .en    (1'b1),
    .total (h_total),
    .q     (sx),
    .q_next(nx),
    .wrap  (h_wrap)
  );

  dt_axis_ctr #(
    .CORDW  (CORDW),
    .RST_VAL(CORDW'(RST_TOT.v - 16'd1))
  ) u_v (
    .clk   (clk_pix),
    .rst_n (rst_pix_n),
    .en    (h_wrap),
    .total (v_total),
    .q     (sy),
    .q_next(ny),
    .wrap  (v_wrap)
  );

  // The frame starting at (0,0) is decoded with the newly requested timing.
  assign t_nxt = v_wrap ? MODES[mode_req] : t_cur;

  assign hs_lo = CORDW'(t_nxt.hres + t_nxt.hfp);
  assign hs_hi = hs_lo + CORDW'(t_nxt.hs);
  assign vs_lo = CORDW'(t_nxt.vres + t_nxt.vfp);
  assign vs_hi = vs_lo + CORDW'(t_nxt.vs);

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      t_cur    <= RST_T;
      mode_act <= 2'(MODE_RST);
      hsync    <= ~RST_T.hpol;
      vsync    <= ~RST_T.vpol;
      de       <= 1'b0;
      frame    <= 1'b0;
      line     <= 1'b0;
    end else begin
      t_cur <= t_nxt;
      if (v_wrap)
        mode_act <= mode_req;
      hsync <= (nx >= hs_lo && nx < hs_hi) ? t_nxt.hpol : ~t_nxt.hpol;
      vsync <= (ny >= vs_lo && ny < vs_hi) ? t_nxt.vpol : ~t_nxt.vpol;
      de    <= (nx < CORDW'(t_nxt.hres)) && (ny < CORDW'(t_nxt.vres));
      frame <= (nx == '0) && (ny == '0);
      line  <= (nx == '0);
    end
  end

endmodule

// File: tb/tb_display_timings_multi.sv
// Scoreboard bench for display_timings_multi: a raster model predicts every cycle,
// a monitor compares the DUT against the queued predictions.
module tb_display_timings_multi;

  localparam int CORDW = 12;

  localparam int H_RES [4] = '{640, 800, 1280, 16};
  localparam int H_FP  [4] = '{16, 40, 110, 2};
  localparam int H_SY  [4] = '{96, 128, 40, 3};
  localparam int H_BP  [4] = '{48, 88, 220, 1};
  localparam int V_RES [4] = '{480, 600, 720, 4};
  localparam int V_FP  [4] = '{10, 1, 5, 1};
  localparam int V_SY  [4] = '{2, 4, 5, 1};
  localparam int V_BP  [4] = '{33, 23, 20, 1};
  localparam bit H_POL [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  localparam bit V_POL [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  localparam int RST_MODE  = 3;

  typedef struct packed {
    logic [1:0]       mode;
    logic [CORDW-1:0] sx;
    logic [CORDW-1:0] sy;
    logic             hs;
    logic             vs;
    logic             de;
    logic             frame;
    logic             line;
  } exp_t;

  logic             clk_pix = 1'b0;
  logic             rst_pix_n = 1'b1;
  logic [1:0]       mode_req = 2'd0;
  logic [1:0]       mode_act;
  logic [CORDW-1:0] sx;
  logic [CORDW-1:0] sy;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic             frame;
  logic             line;

  exp_t exp_q [$];
  int   vectors = 0;
  int   miscompares = 0;
  int   m_mode, m_x, m_y;
  exp_t mon_e;
  bit   have_frame = 1'b0;
  int   since_frame = 0;
  int   frame_mode = 0;

  display_timings_multi #(
    .CORDW(CORDW), .MODE_RST(RST_MODE),
    .C_HRES(16), .C_HFP(2), .C_HS(3), .C_HBP(1),
    .C_VRES(4), .C_VFP(1), .C_VS(1), .C_VBP(1),
    .C_HPOL(1'b1), .C_VPOL(1'b0)
  ) dut (
    .clk_pix  (clk_pix),
    .rst_pix_n(rst_pix_n),
    .mode_req (mode_req),
    .mode_act (mode_act),
    .sx       (sx),
    .sy       (sy),
    .hsync    (hsync),
    .vsync    (vsync),
    .de       (de),
    .frame    (frame),
    .line     (line)
  );

  always #5 clk_pix = ~clk_pix;

  function automatic int htot(input int m);
    return H_RES[m] + H_FP[m] + H_SY[m] + H_BP[m];
  endfunction

  function automatic int vtot(input int m);
    return V_RES[m] + V_FP[m] + V_SY[m] + V_BP[m];
  endfunction

  function automatic exp_t expected_at(input int m, input int x, input int y);
    exp_t e;
    int   hlo, vlo;
    hlo     = H_RES[m] + H_FP[m];
    vlo     = V_RES[m] + V_FP[m];
    e.mode  = 2'(m);
    e.sx    = CORDW'(x);
    e.sy    = CORDW'(y);
    e.hs    = (x >= hlo && x < hlo + H_SY[m]) ? H_POL[m] : ~H_POL[m];
    e.vs    = (y >= vlo && y < vlo + V_SY[m]) ? V_POL[m] : ~V_POL[m];
    e.de    = (x < H_RES[m]) && (y < V_RES[m]);
    e.frame = (x == 0) && (y == 0);
    e.line  = (x == 0);
    return e;
  endfunction

  function automatic exp_t reset_expected();
    exp_t e;
    e.mode  = 2'(RST_MODE);
    e.sx    = CORDW'(htot(RST_MODE) - 1);
    e.sy    = CORDW'(vtot(RST_MODE) - 1);
    e.hs    = ~H_POL[RST_MODE];
    e.vs    = ~V_POL[RST_MODE];
    e.de    = 1'b0;
    e.frame = 1'b0;
    e.line  = 1'b0;
    return e;
  endfunction

  task automatic check_output(input exp_t e, input string name);
    exp_t act;
    act = '{mode: mode_act, sx: sx, sy: sy, hs: hsync, vs: vsync,
            de: de, frame: frame, line: line};
    vectors++;
    if (act !== e) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0t got mode=%0d sx=%0d sy=%0d hs=%b vs=%b de=%b fr=%b ln=%b, expected mode=%0d sx=%0d sy=%0d hs=%b vs=%b de=%b fr=%b ln=%b",
               name, $time, act.mode, act.sx, act.sy, act.hs, act.vs, act.de, act.frame, act.line,
               e.mode, e.sx, e.sy, e.hs, e.vs, e.de, e.frame, e.line);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0t got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Raster position advanced as a linear pixel index within the frame.
  task automatic model_advance(input logic [1:0] req);
    int pos;
    pos = m_y * htot(m_mode) + m_x + 1;
    if (pos == htot(m_mode) * vtot(m_mode)) begin
      pos    = 0;
      m_mode = int'(req);
    end
    m_x = pos % htot(m_mode);
    m_y = pos / htot(m_mode);
  endtask

  // Called at a falling edge: drive the request and predict the next rising edge.
  task automatic apply_stimulus(input logic [1:0] req);
    mode_req = req;
    model_advance(req);
    exp_q.push_back(expected_at(m_mode, m_x, m_y));
    @(negedge clk_pix);
  endtask

  task automatic do_reset(input logic [1:0] req);
    #2;
    rst_pix_n = 1'b0;
    m_mode = RST_MODE;
    m_x    = htot(RST_MODE) - 1;
    m_y    = vtot(RST_MODE) - 1;
    #1;
    check_output(reset_expected(), "async_reset");
    repeat (2) @(negedge clk_pix);
    check_output(reset_expected(), "reset_hold");
    mode_req  = req;
    rst_pix_n = 1'b1;
  endtask

  task automatic run_phase(input logic [1:0] base, input int n, input int chg_odds);
    logic [1:0] req;
    for (int i = 0; i < n; i++) begin
      req = base;
      if (i > 0 && $urandom_range(0, chg_odds) == 0)
        req = 2'($urandom_range(0, 3));
      apply_stimulus(req);
    end
  endtask

  always @(posedge clk_pix) begin
    #1;
    if (!rst_pix_n) begin
      have_frame = 1'b0;
    end else if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_output(mon_e, "scan");
      if (have_frame)
        since_frame++;
      if (frame === 1'b1) begin
        if (have_frame)
          check_int("frame_period", since_frame, htot(frame_mode) * vtot(frame_mode));
        have_frame  = 1'b1;
        since_frame = 0;
        frame_mode  = int'(mon_e.mode);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog t=%0t bench did not complete", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [1:0] base;
    int         n;

    // Stock modes: whole lines from reset with mid-frame request noise.
    do_reset(2'd0);
    run_phase(2'd0, 2 * 800 + 50, 3);
    do_reset(2'd1);
    run_phase(2'd1, 2 * 1056 + 50, 3);
    do_reset(2'd2);
    run_phase(2'd2, 2 * 1650 + 50, 3);

    // Custom mode: two full frames, then request mode 0 mid-frame.
    do_reset(2'd3);
    run_phase(2'd3, 2 * 154 + 60, 1_000_000);
    run_phase(2'd0, 120, 1_000_000);

    // Random resets at arbitrary points with sporadic mode requests.
    for (int it = 0; it < 40; it++) begin
      base = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'd3;
      do_reset(base);
      n = int'($urandom_range(100, 700));
      run_phase((it % 2 == 0) ? 2'd3 : base, n, 9);
    end

    repeat (2) @(negedge clk_pix);
    check_int("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
